// File: rtl/cache_mem_bridge.sv
// Bridge between a cache (line refill / line write-back) and a
// single-outstanding word memory port. One write-back line is buffered;
// refills take priority over draining it.
// Optional feature: define CACHE_BRIDGE_RAW_BYPASS_EN to serve a refill that
// hits the buffered line directly from the buffer instead of draining first.
module cache_mem_bridge (
  input  logic         clk,
  input  logic         resetn,
  input  logic         rd_req,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic         ret_last,
  output logic [31:0]  ret_data,
  input  logic         wr_req,
  input  logic [31:0]  wr_addr,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic         mem_req,
  output logic         mem_wr,
  output logic [3:0]   mem_wstrb,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  input  logic         mem_addr_ok,
  input  logic         mem_data_ok,
  input  logic [31:0]  mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, BYP} state_e;

  state_e        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          outst_q, outst_d;      // address accepted, data pending
  logic          rd_pend_q, rd_pend_d;  // refill waiting behind a drain
  logic [27:0]   line_q, line_d;        // refill line address
  logic          wbuf_valid_q, wbuf_valid_d;
  logic [27:0]   wbuf_line_q, wbuf_line_d;
  logic [127:0]  wbuf_data_q, wbuf_data_d;
  logic          mem_req_q, mem_req_d, mem_wr_q, mem_wr_d;
  logic [31:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic          ret_valid_q, ret_valid_d, ret_last_q, ret_last_d;
  logic [31:0]   ret_data_q, ret_data_d;

  logic [1:0]    cnt_nx;
  logic          wr_acc, raw_hit, beat_done;
  logic          unused_addr_bits;

  assign cnt_nx    = cnt_q + 2'd1;
  assign wr_acc    = wr_req && !wbuf_valid_q;
  assign raw_hit   = wbuf_valid_q && (rd_addr[31:4] == wbuf_line_q);
  // data_ok only counts when a word is actually outstanding
  assign beat_done = outst_q && mem_data_ok;
  assign unused_addr_bits = ^{rd_addr[3:0], wr_addr[3:0]};

  function automatic logic [31:0] wword(input logic [127:0] d, input logic [1:0] i);
    return d[{i, 5'b0} +: 32];
  endfunction

  // Next-state, memory-port and return-path logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    outst_d      = outst_q;
    rd_pend_d    = rd_pend_q;
    line_d       = line_q;
    wbuf_valid_d = wbuf_valid_q;
    wbuf_line_d  = wbuf_line_q;
    wbuf_data_d  = wbuf_data_q;
    mem_req_d    = mem_req_q;
    mem_wr_d     = mem_wr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    ret_valid_d  = 1'b0;
    ret_last_d   = 1'b0;
    ret_data_d   = ret_data_q;

    if (mem_req_q && mem_addr_ok) begin
      mem_req_d = 1'b0;
      outst_d   = 1'b1;
    end
    if (beat_done) outst_d = 1'b0;

    if (wr_acc) begin
      wbuf_valid_d = 1'b1;
      wbuf_line_d  = wr_addr[31:4];
      wbuf_data_d  = wr_data;
    end

    case (state_q)
      IDLE: begin
        if (rd_req) begin
          line_d = rd_addr[31:4];
          cnt_d  = 2'd0;
          if (raw_hit) begin
`ifdef CACHE_BRIDGE_RAW_BYPASS_EN
            // word 0 leaves now, BYP streams words 1..3
            state_d     = BYP;
            ret_valid_d = 1'b1;
            ret_data_d  = wword(wbuf_data_q, 2'd0);
            cnt_d       = 2'd1;
`else
            rd_pend_d   = 1'b1;
            state_d     = WR;
            mem_req_d   = 1'b1;
            mem_wr_d    = 1'b1;
            mem_addr_d  = {wbuf_line_q, 4'h0};
            mem_wdata_d = wword(wbuf_data_q, 2'd0);
`endif
          end else begin
            state_d    = RD;
            mem_req_d  = 1'b1;
            mem_wr_d   = 1'b0;
            mem_addr_d = {rd_addr[31:4], 4'h0};
          end
        end else if (wbuf_valid_q) begin
          state_d     = WR;
          cnt_d       = 2'd0;
          mem_req_d   = 1'b1;
          mem_wr_d    = 1'b1;
          mem_addr_d  = {wbuf_line_q, 4'h0};
          mem_wdata_d = wword(wbuf_data_q, 2'd0);
        end
      end
      RD: begin
        if (beat_done) begin
          ret_valid_d = 1'b1;
          ret_data_d  = mem_rdata;
          ret_last_d  = (cnt_q == 2'd3);
          cnt_d       = cnt_nx;
          if (cnt_q == 2'd3) begin
            state_d = IDLE;
          end else begin
            mem_req_d  = 1'b1;
            mem_addr_d = {line_q, cnt_nx, 2'b00};
          end
        end
      end
      WR: begin
        if (beat_done) begin
          cnt_d = cnt_nx;
          if (cnt_q == 2'd3) begin
            wbuf_valid_d = 1'b0;
            if (rd_pend_q) begin
              rd_pend_d  = 1'b0;
              state_d    = RD;
              mem_req_d  = 1'b1;
              mem_wr_d   = 1'b0;
              mem_addr_d = {line_q, 4'h0};
            end else begin
              state_d = IDLE;
            end
          end else begin
            mem_req_d   = 1'b1;
            mem_addr_d  = {wbuf_line_q, cnt_nx, 2'b00};
            mem_wdata_d = wword(wbuf_data_q, cnt_nx);
          end
        end
      end
      BYP: begin
        ret_valid_d = 1'b1;
        ret_data_d  = wword(wbuf_data_q, cnt_q);
        ret_last_d  = (cnt_q == 2'd3);
        cnt_d       = cnt_nx;
        if (cnt_q == 2'd3) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any burst in progress
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      outst_q      <= 1'b0;
      rd_pend_q    <= 1'b0;
      line_q       <= 28'd0;
      wbuf_valid_q <= 1'b0;
      wbuf_line_q  <= 28'd0;
      wbuf_data_q  <= 128'd0;
      mem_req_q    <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      ret_valid_q  <= 1'b0;
      ret_last_q   <= 1'b0;
      ret_data_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      outst_q      <= outst_d;
      rd_pend_q    <= rd_pend_d;
      line_q       <= line_d;
      wbuf_valid_q <= wbuf_valid_d;
      wbuf_line_q  <= wbuf_line_d;
      wbuf_data_q  <= wbuf_data_d;
      mem_req_q    <= mem_req_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      ret_valid_q  <= ret_valid_d;
      ret_last_q   <= ret_last_d;
      ret_data_q   <= ret_data_d;
    end
  end

  assign rd_rdy    = (state_q == IDLE);
  assign wr_rdy    = !wbuf_valid_q;
  assign mem_req   = mem_req_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wstrb = mem_wr_q ? 4'hF : 4'h0;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign ret_valid = ret_valid_q;
  assign ret_last  = ret_last_q;
  assign ret_data  = ret_data_q;

endmodule

// File: tb/tb_cache_mem_bridge.sv
// Directed bench for cache_mem_bridge with a small word-memory model
// (2-cycle data latency, optional address stall, write-backed store).
module tb_cache_mem_bridge;

  logic         clk, resetn;
  logic         rd_req, rd_rdy, ret_valid, ret_last;
  logic [31:0]  rd_addr, ret_data;
  logic         wr_req, wr_rdy;
  logic [31:0]  wr_addr;
  logic [127:0] wr_data;
  logic         mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [3:0]   mem_wstrb;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata;

  cache_mem_bridge dut (
    .clk(clk), .resetn(resetn),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_rdy(wr_rdy),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0, cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // memory model: accepts on negedge, data_ok 2 cycles later
  logic [31:0] store [logic [31:0]];
  logic [31:0] log_addr [128], log_data [128];
  logic        log_wr [128];
  logic [3:0]  log_strb [128];
  int          log_cyc [128];
  int          nlog = 0, pend = 0, stall_left = 0;
  logic        inj_dok = 1'b0;
  logic [31:0] pend_rdata = 32'd0;

  always @(negedge clk) begin
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    if (!resetn) pend = 0;
    else if (pend > 0) begin
      pend--;
      if (pend == 0) begin mem_data_ok = 1'b1; mem_rdata = pend_rdata; end
    end else if (inj_dok) begin
      mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF; inj_dok = 1'b0;
    end else if (mem_req) begin
      if (stall_left > 0) stall_left--;
      else begin
        mem_addr_ok = 1'b1;
        pend = 2;
        if (nlog < 128) begin
          log_addr[nlog] = mem_addr; log_wr[nlog] = mem_wr; log_data[nlog] = mem_wdata;
          log_strb[nlog] = mem_wstrb; log_cyc[nlog] = cyc;
        end
        nlog++;
        if (mem_wr) begin store[mem_addr] = mem_wdata; pend_rdata = 32'd0; end
        else pend_rdata = store.exists(mem_addr) ? store[mem_addr]
                                                 : 32'hA0 + {30'd0, mem_addr[3:2]};
      end
    end
  end

  // return monitor
  logic [31:0] rv_data [64];
  logic        rv_last [64];
  int          rv_cyc [64];
  int          nret = 0;
  always @(negedge clk) if (resetn && ret_valid) begin
    if (nret < 64) begin rv_data[nret] = ret_data; rv_last[nret] = ret_last; rv_cyc[nret] = cyc; end
    nret++;
  end

  task automatic do_rd(input logic [31:0] a);
    int k = 0;
    @(negedge clk); rd_req = 1'b1; rd_addr = a;
    while (!rd_rdy && k < 400) begin @(negedge clk); k++; end
    chk("rd_accept", rd_rdy, 1);
    @(posedge clk); #1 rd_req = 1'b0;
  endtask

  task automatic do_wr(input logic [31:0] a, input logic [127:0] d);
    int k = 0;
    @(negedge clk); wr_req = 1'b1; wr_addr = a; wr_data = d;
    while (!wr_rdy && k < 400) begin @(negedge clk); k++; end
    chk("wr_accept", wr_rdy, 1);
    @(posedge clk); #1 wr_req = 1'b0;
  endtask

  task automatic wait_ret(input int n);
    int k = 0;
    while (nret < n && k < 400) begin @(negedge clk); k++; end
    chk("ret_count", nret, n);
  endtask

  task automatic wait_wr_free();
    int k = 0;
    while (!wr_rdy && k < 400) begin @(negedge clk); k++; end
    chk("wr_drain", wr_rdy, 1);
  endtask

  int b, r;
  logic [31:0] a0, d0;

  initial begin
    resetn = 1'b0; rd_req = 1'b0; rd_addr = 32'd0; wr_req = 1'b0;
    wr_addr = 32'd0; wr_data = 128'd0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_rd_rdy", rd_rdy, 1);     chk("rst_wr_rdy", wr_rdy, 1);
    chk("rst_mem_req", mem_req, 0);   chk("rst_ret_valid", ret_valid, 0);
    chk("rst_ret_last", ret_last, 0); chk("rst_ret_data", ret_data, 0);
    chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_wdata", mem_wdata, 0);
    resetn = 1'b1;
    @(negedge clk);

    // refill 0x1234_5670
    b = nlog; r = nret;
    do_rd(32'h1234_5670);
    wait_ret(r + 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", log_addr[b+i], 32'h1234_5670 + 4*i);
      chk("t1_wr", log_wr[b+i], 0);
      chk("t1_data", rv_data[r+i], 32'hA0 + i);
      chk("t1_last", rv_last[r+i], (i == 3) ? 1 : 0);
    end
    repeat (3) @(negedge clk);

    // write-back 0x100
    b = nlog;
    do_wr(32'h100, {32'h44, 32'h33, 32'h22, 32'h11});
    chk("t2_wr_rdy_low", wr_rdy, 0);
    wait_wr_free();
    chk("t2_nwrites", nlog - b, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_addr", log_addr[b+i], 32'h100 + 4*i);
      chk("t2_wr", log_wr[b+i], 1);
      chk("t2_wdata", log_data[b+i], 32'h11 * (i + 1));
      chk("t2_strb", log_strb[b+i], 4'hF);
    end
    repeat (3) @(negedge clk);

    // simultaneous write 0x200 and read 0x300
    b = nlog; r = nret;
    @(negedge clk);
    rd_req = 1'b1; rd_addr = 32'h300;
    wr_req = 1'b1; wr_addr = 32'h200; wr_data = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    chk("t3_both_rdy", {rd_rdy, wr_rdy}, 2'b11);
    @(posedge clk); #1 rd_req = 1'b0; wr_req = 1'b0;
    wait_ret(r + 4);
    wait_wr_free();
    for (int i = 0; i < 4; i++) begin
      chk("t3_rd_addr", log_addr[b+i], 32'h300 + 4*i);
      chk("t3_rd_dir", log_wr[b+i], 0);
      chk("t3_wr_addr", log_addr[b+4+i], 32'h200 + 4*i);
      chk("t3_wr_dir", log_wr[b+4+i], 1);
      chk("t3_wr_data", log_data[b+4+i], 32'hB0 + i);
    end
    repeat (3) @(negedge clk);

    // RAW: buffer holds 0x400 (accepted during refill 0x600), then read 0x404
    b = nlog; r = nret;
    do_rd(32'h600);
    do_wr(32'h400, {32'h88, 32'h77, 32'h66, 32'h55});
    do_rd(32'h404);
    wait_ret(r + 8);
    wait_wr_free();
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("t4_ref_addr", log_addr[b+i], 32'h600 + 4*i);
      chk("t4_raw_data", rv_data[r+4+i], 32'h55 + 32'h11 * i);
      chk("t4_raw_last", rv_last[r+4+i], (i == 3) ? 1 : 0);
      chk("t4_drain_addr", log_addr[b+4+i], 32'h400 + 4*i);
      chk("t4_drain_dir", log_wr[b+4+i], 1);
    end
`ifdef CACHE_BRIDGE_RAW_BYPASS_EN
    for (int i = 1; i < 4; i++) chk("t4_byp_consec", rv_cyc[r+4+i] - rv_cyc[r+4], i);
    chk("t4_no_mem_before_byp", (log_cyc[b+4] > rv_cyc[r+7]) ? 1 : 0, 1);
    chk("t4_nmem", nlog - b, 8);
`else
    for (int i = 0; i < 4; i++) begin
      chk("t4_rd_after_addr", log_addr[b+8+i], 32'h400 + 4*i);
      chk("t4_rd_after_dir", log_wr[b+8+i], 0);
    end
    chk("t4_nmem", nlog - b, 12);
`endif

    // reset during 3rd refill word, then fresh refill 0x500
    r = nret;
    do_rd(32'h700);
    wait_ret(r + 2);
    resetn = 1'b0;
    #1;
    chk("t5_mem_req", mem_req, 0);   chk("t5_ret_valid", ret_valid, 0);
    chk("t5_ret_data", ret_data, 0); chk("t5_mem_addr", mem_addr, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("t5_rd_rdy", rd_rdy, 1);
    b = nlog; r = nret;
    do_rd(32'h500);
    wait_ret(r + 4);
    for (int i = 0; i < 4; i++) begin
      chk("t5_addr", log_addr[b+i], 32'h500 + 4*i);
      chk("t5_data", rv_data[r+i], 32'hA0 + i);
      chk("t5_last", rv_last[r+i], (i == 3) ? 1 : 0);
    end
    repeat (3) @(negedge clk);

    // addr_ok stalled 5 cycles on a write-back, with a stray data_ok inside
    b = nlog;
    stall_left = 5;
    do_wr(32'h900, {32'h94, 32'h93, 32'h92, 32'h91});
    for (int k = 0; k < 20 && !mem_req; k++) @(negedge clk);
    a0 = mem_addr; d0 = mem_wdata;
    chk("t6_first_addr", a0, 32'h900);
    chk("t6_first_wdata", d0, 32'h91);
    for (int i = 0; i < 6; i++) begin
      chk("t6_req_stable", mem_req, 1);
      chk("t6_addr_stable", mem_addr, a0);
      chk("t6_wdata_stable", mem_wdata, d0);
      if (i == 2) inj_dok = 1'b1;
      @(negedge clk);
    end
    wait_wr_free();
    chk("t6_nwrites", nlog - b, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t6_addr", log_addr[b+i], 32'h900 + 4*i);
      chk("t6_wdata", log_data[b+i], 32'h91 + i);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
